// File: rtl/pim_dma_ctrl.sv
// pim_dma_ctrl: single-channel DMA sequencer moving 32-bit words between
// data memory and one of NUM_PIM PIM macros. One word is read from the
// source, buffered, then written to the destination. The shared dmem port
// is obtained through req/gnt. busy_o stalls the core until the transfer ends.
module pim_dma_ctrl #(
    parameter int XLEN    = 32,
    parameter int SIZE_W  = 13,
    parameter int NUM_PIM = 4,
    parameter int PIM_AW  = 12
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_en_i,
    input  logic [2:0]         cmd_funct3_i,
    input  logic [NUM_PIM-1:0] cmd_sel_pim_i,
    input  logic [SIZE_W-1:0]  cmd_size_i,
    input  logic [XLEN-1:0]    cmd_mem_addr_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic [XLEN-1:0]    mem_addr_o,
    output logic [XLEN-1:0]    mem_wr_data_o,
    output logic [3:0]         mem_size_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    input  logic [XLEN-1:0]    mem_rd_data_i,
    output logic [NUM_PIM-1:0] pim_sel_o,
    output logic [PIM_AW-1:0]  pim_addr_o,
    output logic [XLEN-1:0]    pim_wr_data_o,
    output logic               pim_read_o,
    output logic               pim_write_o,
    input  logic [XLEN-1:0]    pim_rd_data_i
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SRC_RD   = 3'd1;
    localparam logic [2:0] SRC_WAIT = 3'd2;
    localparam logic [2:0] DST_WR   = 3'd3;
    localparam logic [2:0] FINISH   = 3'd4;

    localparam logic [2:0] F3_MEM2PIM = 3'b000;
    localparam logic [2:0] F3_PIM2MEM = 3'b001;

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic               busy;
    logic               err;
    logic               dir_p2m;
    logic [NUM_PIM-1:0] sel;
    logic [SIZE_W-1:0]  size;
    logic [SIZE_W-1:0]  word_cnt;
    logic [SIZE_W-1:0]  word_cnt_inc;
    logic [XLEN-1:0]    mem_addr;
    logic [PIM_AW-1:0]  pim_addr;
    logic [XLEN-1:0]    data_buf;

    logic               sel_onehot;
    logic               funct_ok;
    logic               cmd_legal;
    logic               cmd_accept;
    logic               cmd_reject;
    logic               word_done;
    logic               last_word;
    logic               in_xfer;
    logic               mem_req;

    // Command qualification: only evaluated while idle.
    assign sel_onehot   = (cmd_sel_pim_i != '0) &&
                          ((cmd_sel_pim_i & (cmd_sel_pim_i - 1'b1)) == '0);
    assign funct_ok     = (cmd_funct3_i == F3_MEM2PIM) || (cmd_funct3_i == F3_PIM2MEM);
    assign cmd_legal    = funct_ok && sel_onehot && (cmd_mem_addr_i[1:0] == 2'b00);
    assign cmd_accept   = (state == IDLE) && cmd_en_i && cmd_legal;
    assign cmd_reject   = (state == IDLE) && cmd_en_i && !cmd_legal;

    // A destination write completes immediately on the PIM side, but must
    // wait for the grant when the destination is dmem.
    assign word_done    = (state == DST_WR) && (!dir_p2m || mem_gnt_i);
    assign word_cnt_inc = word_cnt + 1'b1;
    assign last_word    = (word_cnt_inc == size);
    assign in_xfer      = (state == SRC_RD) || (state == SRC_WAIT) || (state == DST_WR);

    // Next-state decode for the word sequencer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    next_state = (cmd_size_i == '0) ? FINISH : SRC_RD;
                end
            end
            SRC_RD: begin
                if (dir_p2m || mem_gnt_i) begin
                    next_state = SRC_WAIT;
                end
            end
            SRC_WAIT: begin
                next_state = DST_WR;
            end
            DST_WR: begin
                if (word_done) begin
                    next_state = last_word ? FINISH : SRC_RD;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register plus registered busy/err status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            err   <= cmd_reject;
        end
    end

    // Command latch and per-word address/count advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_p2m  <= 1'b0;
            sel      <= '0;
            size     <= '0;
            word_cnt <= '0;
            mem_addr <= '0;
            pim_addr <= '0;
        end else if (cmd_accept && (cmd_size_i != '0)) begin
            dir_p2m  <= (cmd_funct3_i == F3_PIM2MEM);
            sel      <= cmd_sel_pim_i;
            size     <= cmd_size_i;
            word_cnt <= '0;
            mem_addr <= cmd_mem_addr_i;
            pim_addr <= '0;
        end else if (word_done) begin
            word_cnt <= word_cnt_inc;
            mem_addr <= mem_addr + XLEN'(4);
            pim_addr <= pim_addr + 1'b1;
        end
    end

    // Word buffer: source data arrives the cycle after the read request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_buf <= '0;
        end else if (state == SRC_WAIT) begin
            data_buf <= dir_p2m ? pim_rd_data_i : mem_rd_data_i;
        end
    end

    // dmem is the source in MEM2PIM and the destination in PIM2MEM.
    assign mem_req       = ((state == SRC_RD) && !dir_p2m) || ((state == DST_WR) && dir_p2m);
    assign mem_req_o     = mem_req;
    assign mem_read_o    = mem_req && !dir_p2m;
    assign mem_write_o   = mem_req && dir_p2m;
    assign mem_addr_o    = mem_req ? mem_addr : '0;
    assign mem_wr_data_o = (mem_req && dir_p2m) ? data_buf : '0;
    assign mem_size_o    = mem_req ? 4'b1111 : 4'b0000;

    assign pim_read_o    = (state == SRC_RD) && dir_p2m;
    assign pim_write_o   = (state == DST_WR) && !dir_p2m;
    assign pim_sel_o     = in_xfer ? sel : '0;
    assign pim_addr_o    = in_xfer ? pim_addr : '0;
    assign pim_wr_data_o = pim_write_o ? data_buf : '0;

    assign busy_o        = busy;
    assign done_o        = (state == FINISH);
    assign err_o         = err;

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// Testbench for pim_dma_ctrl: directed commands against simple dmem/PIM
// models; expected events are queued when issued and popped by a monitor.
module tb_pim_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_en_i = 1'b0;
    logic [2:0]  cmd_funct3_i = '0;
    logic [3:0]  cmd_sel_pim_i = '0;
    logic [12:0] cmd_size_i = '0;
    logic [31:0] cmd_mem_addr_i = '0;
    logic        busy_o, done_o, err_o;
    logic        mem_req_o, mem_gnt_i;
    logic [31:0] mem_addr_o, mem_wr_data_o;
    logic [3:0]  mem_size_o;
    logic        mem_read_o, mem_write_o;
    logic [31:0] mem_rd_data_i = '0;
    logic [3:0]  pim_sel_o;
    logic [11:0] pim_addr_o;
    logic [31:0] pim_wr_data_o;
    logic        pim_read_o, pim_write_o;
    logic [31:0] pim_rd_data_i = '0;

    pim_dma_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .cmd_en_i       (cmd_en_i),
        .cmd_funct3_i   (cmd_funct3_i),
        .cmd_sel_pim_i  (cmd_sel_pim_i),
        .cmd_size_i     (cmd_size_i),
        .cmd_mem_addr_i (cmd_mem_addr_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_size_o     (mem_size_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_rd_data_i  (mem_rd_data_i),
        .pim_sel_o      (pim_sel_o),
        .pim_addr_o     (pim_addr_o),
        .pim_wr_data_o  (pim_wr_data_o),
        .pim_read_o     (pim_read_o),
        .pim_write_o    (pim_write_o),
        .pim_rd_data_i  (pim_rd_data_i)
    );

    always #5 clk = ~clk;

    // Event kinds carried through the scoreboard.
    localparam logic [31:0] K_PIMWR = 32'd0;
    localparam logic [31:0] K_MEMWR = 32'd1;
    localparam logic [31:0] K_DONE  = 32'd2;
    localparam logic [31:0] K_ERR   = 32'd3;

    typedef struct packed {
        logic [31:0] kind;
        logic [31:0] sel;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];

    logic [31:0] dmem [0:1023];
    logic [31:0] pim_mem [0:3][0:15];

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int busy_cnt = 0;
    int gnt_delay = 0;
    int wait_cnt = 0;

    wire [127:0] outs_all = {4'b0, busy_o, done_o, err_o, mem_req_o, mem_read_o, mem_write_o,
                             mem_addr_o, mem_wr_data_o, mem_size_o, pim_sel_o, pim_addr_o,
                             pim_wr_data_o, pim_read_o, pim_write_o};

    // Grant arbiter model: grant after gnt_delay stalled cycles.
    assign mem_gnt_i = mem_req_o && (wait_cnt >= gnt_delay);

    always @(posedge clk) begin
        if (mem_req_o && !mem_gnt_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // dmem read data appears the cycle after grant.
    always @(posedge clk) begin
        if (mem_req_o && mem_read_o && mem_gnt_i) mem_rd_data_i <= dmem[mem_addr_o[11:2]];
    end

    function automatic int sel_idx(input logic [3:0] s);
        case (s)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    // PIM read data appears the cycle after pim_read_o.
    always @(posedge clk) begin
        if (pim_read_o) pim_rd_data_i <= pim_mem[sel_idx(pim_sel_o)][pim_addr_o[3:0]];
    end

    task automatic check_wide(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] kind, input logic [31:0] sel,
                        input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind; e.sel = sel; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string name, input ev_t obs);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_wide({name, "_unexpected"}, obs, 128'b0);
        end else begin
            e = exp_q.pop_front();
            check_wide(name, obs, e);
        end
    endtask

    // Monitor: pops the expected event whenever the DUT presents one.
    task automatic monitor();
        ev_t obs;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (mem_req_o || pim_read_o || pim_write_o) strobe_cnt++;
                if (busy_o) busy_cnt++;
                if (pim_write_o) begin
                    obs = '{K_PIMWR, 32'(pim_sel_o), 32'(pim_addr_o), pim_wr_data_o};
                    pop_cmp("pim_write", obs);
                end
                if (mem_req_o && mem_write_o) begin
                    if (!mem_gnt_i) begin
                        if (exp_q.size() != 0)
                            check_wide("stall_addr_data", {64'b0, mem_addr_o, mem_wr_data_o},
                                       {64'b0, exp_q[0].addr, exp_q[0].data});
                        else
                            check_wide("stall_unexpected", {64'b0, mem_addr_o, mem_wr_data_o}, 128'b0);
                    end else begin
                        obs = '{K_MEMWR, 32'b0, mem_addr_o, mem_wr_data_o};
                        pop_cmp("mem_write", obs);
                    end
                end
                if (done_o) pop_cmp("done", '{K_DONE, 32'b0, 32'b0, 32'b0});
                if (err_o) pop_cmp("err", '{K_ERR, 32'b0, 32'b0, 32'b0});
            end
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [3:0] s,
                         input logic [12:0] sz, input logic [31:0] a);
        @(posedge clk); #1;
        cmd_en_i = 1'b1; cmd_funct3_i = f3; cmd_sel_pim_i = s;
        cmd_size_i = sz; cmd_mem_addr_i = a;
        @(posedge clk); #1;
        cmd_en_i = 1'b0; cmd_funct3_i = '0; cmd_sel_pim_i = '0;
        cmd_size_i = '0; cmd_mem_addr_i = '0;
    endtask

    task automatic wait_idle(input string name, input int bound, output int nbusy);
        bit ended = 0;
        nbusy = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy_o) nbusy++;
            else if (nbusy > 0) begin ended = 1; break; end
        end
        check_int({name, "_completes"}, int'(ended), 1);
    endtask

    initial begin
        int nb;
        int s0, b0;
        bit found;

        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        for (int p = 0; p < 4; p++)
            for (int w = 0; w < 16; w++) pim_mem[p][w] = '0;
        dmem[32'h100 >> 2] = 32'hA5A5_0001;
        dmem[32'h104 >> 2] = 32'hA5A5_0002;
        dmem[32'h300 >> 2] = 32'h3333_0000;
        dmem[32'h304 >> 2] = 32'h3333_0001;
        dmem[32'h308 >> 2] = 32'h3333_0002;
        dmem[32'h30C >> 2] = 32'h3333_0003;
        dmem[32'h400 >> 2] = 32'h1111_0000;
        dmem[32'h404 >> 2] = 32'h1111_0001;
        dmem[32'h408 >> 2] = 32'h1111_0002;
        dmem[32'h40C >> 2] = 32'h1111_0003;
        pim_mem[2][0] = 32'hC0DE_0000;
        pim_mem[2][1] = 32'hC0DE_0001;
        pim_mem[2][2] = 32'hC0DE_0002;

        fork
            monitor();
        join_none

        // Reset state.
        repeat (2) @(negedge clk);
        check_wide("reset_outputs", outs_all, 128'b0);
        rst_ni = 1'b1;
        @(negedge clk);
        check_wide("idle_outputs", outs_all, 128'b0);

        // MEM2PIM, 2 words, grant always high.
        gnt_delay = 0;
        push(K_PIMWR, 32'h1, 32'h0, 32'hA5A5_0001);
        push(K_PIMWR, 32'h1, 32'h1, 32'hA5A5_0002);
        push(K_DONE, 0, 0, 0);
        issue(3'b000, 4'b0001, 13'd2, 32'h100);
        wait_idle("m2p", 40, nb);
        check_int("m2p_busy_cycles", nb, 7);
        check_int("m2p_drained", exp_q.size(), 0);
        check_int("idle_pim_sel", int'(pim_sel_o), 0);

        // PIM2MEM, 3 words, two stall cycles on each grant.
        gnt_delay = 2;
        push(K_MEMWR, 0, 32'h200, 32'hC0DE_0000);
        push(K_MEMWR, 0, 32'h204, 32'hC0DE_0001);
        push(K_MEMWR, 0, 32'h208, 32'hC0DE_0002);
        push(K_DONE, 0, 0, 0);
        issue(3'b001, 4'b0100, 13'd3, 32'h200);
        wait_idle("p2m", 60, nb);
        check_int("p2m_busy_cycles", nb, 16);
        check_int("p2m_drained", exp_q.size(), 0);
        gnt_delay = 0;

        // Illegal commands: bad funct3, non-one-hot select, misaligned address.
        s0 = strobe_cnt; b0 = busy_cnt;
        push(K_ERR, 0, 0, 0);
        issue(3'b010, 4'b0001, 13'd1, 32'h100);
        push(K_ERR, 0, 0, 0);
        issue(3'b000, 4'b0011, 13'd1, 32'h100);
        push(K_ERR, 0, 0, 0);
        issue(3'b001, 4'b0001, 13'd1, 32'h102);
        repeat (3) @(negedge clk);
        check_int("illegal_strobes", strobe_cnt - s0, 0);
        check_int("illegal_busy", busy_cnt - b0, 0);
        check_int("illegal_drained", exp_q.size(), 0);

        // Legal zero-length command.
        s0 = strobe_cnt;
        push(K_DONE, 0, 0, 0);
        issue(3'b000, 4'b0001, 13'd0, 32'h500);
        wait_idle("size0", 20, nb);
        check_int("size0_busy_cycles", nb, 1);
        check_int("size0_strobes", strobe_cnt - s0, 0);
        check_int("size0_drained", exp_q.size(), 0);

        // 4-word transfer with a second command arriving mid-transfer.
        for (int w = 0; w < 4; w++) push(K_PIMWR, 32'h8, w, 32'h3333_0000 + w);
        push(K_DONE, 0, 0, 0);
        issue(3'b000, 4'b1000, 13'd4, 32'h300);
        repeat (2) @(posedge clk);
        issue(3'b001, 4'b0001, 13'd5, 32'h600);
        wait_idle("ignored_cmd", 60, nb);
        check_int("ignored_drained", exp_q.size(), 0);

        // Reset asserted during DST_WR of word 1 of a 4-word transfer.
        push(K_PIMWR, 32'h2, 32'h0, 32'h1111_0000);
        push(K_PIMWR, 32'h2, 32'h1, 32'h1111_0001);
        issue(3'b000, 4'b0010, 13'd4, 32'h400);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pim_write_o && pim_addr_o == 12'd1) begin found = 1; break; end
        end
        check_int("reach_word1_dst_wr", int'(found), 1);
        #1 rst_ni = 1'b0;
        #1 check_wide("midreset_outputs", outs_all, 128'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_wide("midreset_held", outs_all, 128'b0);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check_int("midreset_no_done", exp_q.size(), 0);

        push(K_PIMWR, 32'h2, 32'h0, 32'h1111_0000);
        push(K_PIMWR, 32'h2, 32'h1, 32'h1111_0001);
        push(K_DONE, 0, 0, 0);
        issue(3'b000, 4'b0010, 13'd2, 32'h400);
        wait_idle("after_reset", 40, nb);
        check_int("after_reset_busy_cycles", nb, 7);

        repeat (3) @(negedge clk);
        check_int("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pim_dma_ctrl.md
Name: pim_dma_ctrl

Overview:
Single-channel DMA sequencer that executes the core's DMA commands (dma_en/funct3/sel_pim/size/mem_addr). It moves 32-bit words between data memory and one of four PIM macros. It requests the shared dmem port through the existing req/gnt arbitration. It drives the core's dma_busy_i so the pipeline stalls until the transfer completes.

Parameters:
XLEN, 32, data/address width
SIZE_W, 13, width of word-count field
NUM_PIM, 4, number of PIM macros (one-hot select width)
PIM_AW, 12, PIM word-address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset (see Behaviour)
cmd_en_i  in  1  command strobe, one cycle
cmd_funct3_i  in  3  000=MEM2PIM, 001=PIM2MEM, others illegal
cmd_sel_pim_i  in  NUM_PIM  one-hot target PIM
cmd_size_i  in  SIZE_W  transfer length in 32-bit words
cmd_mem_addr_i  in  XLEN  dmem byte start address
busy_o  out  1  transfer in progress (to core dma_busy_i)
done_o  out  1  one-cycle pulse on completion
err_o  out  1  one-cycle pulse on rejected command
mem_req_o  out  1  dmem port request
mem_gnt_i  in  1  dmem port grant
mem_addr_o  out  XLEN  dmem byte address
mem_wr_data_o  out  XLEN  dmem write data
mem_size_o  out  4  byte enables, always 4'b1111 while active
mem_read_o / mem_write_o  out  1 each  dmem access type
mem_rd_data_i  in  XLEN  dmem read data, valid the cycle after grant
pim_sel_o  out  NUM_PIM  one-hot PIM select, 0 when idle
pim_addr_o  out  PIM_AW  PIM word address
pim_wr_data_o  out  XLEN  PIM write data
pim_read_o / pim_write_o  out  1 each  PIM strobes
pim_rd_data_i  in  XLEN  PIM read data, valid the cycle after pim_read_o

Behaviour:
- Reset is asynchronous and active-low (rst_ni); clock is clk_i. Reset forces the FSM to IDLE and clears the counters, the data buffer, and every output to 0. It applies at any time, including mid-transfer: no further mem/pim strobes are issued and no done_o pulse is produced.
- FSM states: IDLE, SRC_RD, SRC_WAIT, DST_WR, FINISH.
- IDLE, cmd_en_i=1, command checks:
  - Reject if funct3 is not 000/001, sel_pim is not one-hot, or mem_addr[1:0]!=0. On reject, err_o pulses the next cycle and the FSM stays in IDLE.
  - A legal command with size=0 goes directly to FINISH.
  - Otherwise latch funct3, sel, size and mem_addr, clear word_cnt and pim_addr, and go to SRC_RD.
- busy_o is registered: high from the cycle after acceptance through the FINISH cycle inclusive. A rejected command never raises busy_o.
- MEM2PIM word sequence:
  - SRC_RD: assert mem_req_o and mem_read_o; hold the address until mem_gnt_i=1, then go to SRC_WAIT.
  - SRC_WAIT: capture mem_rd_data_i into the buffer.
  - DST_WR: assert pim_write_o with pim_addr and the buffer for one cycle.
- PIM2MEM word sequence:
  - SRC_RD: assert pim_read_o for one cycle.
  - SRC_WAIT: capture pim_rd_data_i.
  - DST_WR: assert mem_req_o and mem_write_o with the buffer; hold until mem_gnt_i=1.
- mem_req_o is asserted only in SRC_RD (MEM2PIM) or DST_WR (PIM2MEM). The address and data it carries stay stable until grant.
- After each completed DST_WR: word_cnt+1, mem_addr+4, pim_addr+1. If word_cnt+1==size, go to FINISH; else go to SRC_RD.
- Throughput with gnt tied high is 3 cycles per word.
- mem_addr wraps modulo 2^XLEN and pim_addr wraps modulo 2^PIM_AW silently.
- FINISH: done_o=1 for one cycle, then IDLE. The next command may be accepted in the first IDLE cycle.
- cmd_en_i while not in IDLE is ignored, with no err_o.
- pim_sel_o equals the latched sel during SRC_RD..DST_WR and is 0 otherwise.

Test Plan:
- Reset check -> all outputs 0 while rst_ni=0.
- MEM2PIM, sel=0001, size=2, addr=0x100, gnt=1, dmem[0x100]=0xA5A5_0001, dmem[0x104]=0xA5A5_0002:
  - Required: PIM0 writes addr0=0xA5A5_0001 and addr1=0xA5A5_0002.
  - busy_o high 7 cycles; done_o pulses once.
- PIM2MEM, sel=0100, size=3, addr=0x200, gnt low for 2 cycles on each request:
  - Required: PIM2 words 0..2 land at 0x200/0x204/0x208.
  - mem_addr and mem_wr_data stay stable during the gnt stall.
- Illegal commands, one each: funct3=010, sel=0011, addr=0x102:
  - Required: err_o pulses once per command; busy_o, mem_req_o and pim strobes stay 0.
- size=0 legal command -> busy_o 1 cycle, done_o pulse, no mem/pim strobes. A second cmd_en_i during a 4-word transfer is ignored.
- rst_ni asserted in DST_WR of word 1 of a 4-word transfer -> outputs 0 immediately, no done_o. A fresh command afterwards executes correctly from word 0.
